// File: rtl/overlap.sv
// Overlap-add stage: adds the stored second half of the previous frame to the first half
// of the current frame, with 65-bit saturation and a one-deep registered output.
module overlap #(
  parameter int unsigned FRAME_LEN = 36,
  parameter int unsigned HALF      = FRAME_LEN / 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  in_overlap_clock,
  input  logic [1:0]  in_overlap_reset,
  input  logic [1:0]  in_overlap_carregar,
  input  logic [1:0]  in_overlap_acionar,
  input  logic [64:0] in_overlap_pcmSample,
  input  logic        in_overlap_valid,
  output logic        in_overlap_ready,
  output logic [64:0] out_overlap_pcmSample,
  output logic [1:0]  out_overlap_armazenarDados,
  output logic        out_overlap_valid,
  input  logic        out_overlap_ready
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned DW    = 65;
  localparam logic [DW-1:0] SAT_POS = {1'b0, {64{1'b1}}};
  localparam logic [DW-1:0] SAT_NEG = {1'b1, {64{1'b0}}};

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    hist_q [HALF];
  logic [DW-1:0]    hist_d [HALF];
  logic [DW-1:0]    out_pcm_q, out_pcm_d;
  logic [1:0]       out_arm_q, out_arm_d;
  logic             out_valid_q, out_valid_d;

  logic [IDX_W-1:0] cur_idx, hist_idx;
  logic [DW-1:0]    hist_rd, sat_sum;
  logic [DW:0]      sum;
  logic             in_xfer, first_half;

  // Reserved payload bits are accepted but have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{in_overlap_clock, in_overlap_reset[1],
                           in_overlap_carregar[1], in_overlap_acionar[1]};

  assign in_overlap_ready           = !out_valid_q || out_overlap_ready;
  assign out_overlap_pcmSample      = out_pcm_q;
  assign out_overlap_armazenarDados = out_arm_q;
  assign out_overlap_valid          = out_valid_q;

  // Sample position, history lookup and saturating sum
  always_comb begin
    in_xfer    = in_overlap_valid && in_overlap_ready;
    cur_idx    = in_overlap_acionar[0] ? '0 : idx_q;
    first_half = (cur_idx < IDX_W'(HALF));
    hist_idx   = cur_idx - IDX_W'(HALF);
    hist_rd    = '0;
    for (int unsigned i = 0; i < HALF; i++) begin
      if (cur_idx == IDX_W'(i)) hist_rd = hist_q[i];
    end
    if (in_overlap_reset[0]) hist_rd = '0;
    sum = {in_overlap_pcmSample[DW-1], in_overlap_pcmSample} + {hist_rd[DW-1], hist_rd};
    if (sum[DW] != sum[DW-1]) sat_sum = sum[DW] ? SAT_NEG : SAT_POS;
    else                      sat_sum = sum[DW-1:0];
  end

  // Next-state: counter, history updates and output register
  always_comb begin
    idx_d       = idx_q;
    hist_d      = hist_q;
    out_pcm_d   = out_pcm_q;
    out_arm_d   = out_arm_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_overlap_ready) begin
      out_valid_d = 1'b0;
      out_arm_d   = 2'b00;
    end

    if (in_xfer) begin
      idx_d = (cur_idx == IDX_W'(FRAME_LEN - 1)) ? '0 : cur_idx + IDX_W'(1);
      if (in_overlap_reset[0]) begin
        for (int unsigned i = 0; i < HALF; i++) hist_d[i] = '0;
      end
      if (first_half) begin
        out_pcm_d   = in_overlap_carregar[0] ? in_overlap_pcmSample : sat_sum;
        out_valid_d = 1'b1;
        out_arm_d   = {cur_idx == IDX_W'(HALF - 1), 1'b1};
      end else begin
        // Store happens after any clear requested by the same sample
        for (int unsigned i = 0; i < HALF; i++) begin
          if (hist_idx == IDX_W'(i)) hist_d[i] = in_overlap_pcmSample;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q       <= '0;
      out_pcm_q   <= '0;
      out_arm_q   <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < HALF; i++) hist_q[i] <= '0;
    end else begin
      idx_q       <= idx_d;
      out_pcm_q   <= out_pcm_d;
      out_arm_q   <= out_arm_d;
      out_valid_q <= out_valid_d;
      hist_q      <= hist_d;
    end
  end

endmodule

// File: tb/tb_overlap.sv
// Bench for overlap: directed frames plus random traffic checked against a queue-based model.
module tb_overlap;

  localparam int unsigned FRAME_LEN = 36;
  localparam int unsigned HALF      = 18;
  localparam logic signed [66:0] MAXV = 67'sh0_FFFF_FFFF_FFFF_FFFF;
  localparam logic signed [66:0] MINV = -MAXV - 67'sd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_clock, in_rst, in_carr, in_acion;
  logic [64:0] in_pcm;
  logic        in_valid, in_ready;
  logic [64:0] out_pcm;
  logic [1:0]  out_arm;
  logic        out_valid, out_ready;

  always #5 clk = ~clk;

  overlap #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk                        (clk),
    .reset                      (rst_n),
    .in_overlap_clock           (in_clock),
    .in_overlap_reset           (in_rst),
    .in_overlap_carregar        (in_carr),
    .in_overlap_acionar         (in_acion),
    .in_overlap_pcmSample       (in_pcm),
    .in_overlap_valid           (in_valid),
    .in_overlap_ready           (in_ready),
    .out_overlap_pcmSample      (out_pcm),
    .out_overlap_armazenarDados (out_arm),
    .out_overlap_valid          (out_valid),
    .out_overlap_ready          (out_ready)
  );

  // Reference state: previous-frame second half, frame position, pending outputs
  logic [64:0] m_hist [HALF];
  int          m_idx;
  logic [64:0] q_pcm [$];
  logic        q_last [$];

  int          errors = 0;
  int          checks = 0;
  int          beats;
  logic [64:0] last_out;
  logic [1:0]  last_arm;
  logic        stall_prev;
  logic [64:0] stall_pcm;
  logic [1:0]  stall_arm;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] sat_add(input logic [64:0] a, input logic [64:0] b);
    logic signed [66:0] s;
    s = $signed({{2{a[64]}}, a}) + $signed({{2{b[64]}}, b});
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return s[64:0];
  endfunction

  // One clock: check outputs, advance the model with this cycle's handshakes, step the clock
  task automatic cycle();
    logic        exp_valid;
    logic [64:0] e_pcm;
    logic        e_last;
    int          i;
    #1;
    exp_valid = (q_pcm.size() > 0);
    chk("out_valid", 65'(out_valid), 65'(exp_valid));
    chk("in_ready", 65'(in_ready), 65'(!exp_valid || out_ready));
    if (!out_valid) chk("arm_idle", 65'(out_arm), 65'd0);
    if (stall_prev) begin
      chk("hold_pcm", out_pcm, stall_pcm);
      chk("hold_arm", 65'(out_arm), 65'(stall_arm));
    end
    stall_prev = rst_n && out_valid && !out_ready;
    stall_pcm  = out_pcm;
    stall_arm  = out_arm;
    if (exp_valid && out_ready) begin
      e_pcm  = q_pcm.pop_front();
      e_last = q_last.pop_front();
      chk("out_pcm", out_pcm, e_pcm);
      chk("out_arm", 65'(out_arm), 65'({e_last, 1'b1}));
      last_out = out_pcm;
      last_arm = out_arm;
      beats++;
    end
    if (!rst_n) begin
      m_idx = 0;
      foreach (m_hist[k]) m_hist[k] = '0;
      q_pcm.delete();
      q_last.delete();
    end else if (in_valid && (!exp_valid || out_ready)) begin
      i = in_acion[0] ? 0 : m_idx;
      if (in_rst[0]) foreach (m_hist[k]) m_hist[k] = '0;
      if (i < HALF) begin
        q_pcm.push_back(in_carr[0] ? in_pcm : sat_add(in_pcm, m_hist[i]));
        q_last.push_back(i == HALF - 1);
      end else begin
        m_hist[i - HALF] = in_pcm;
      end
      m_idx = (i + 1) % FRAME_LEN;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [64:0] s, input logic [1:0] r = 2'b00,
                      input logic [1:0] c = 2'b00, input logic [1:0] a = 2'b00);
    in_valid = 1'b1; in_pcm = s; in_rst = r; in_carr = c; in_acion = a; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; in_rst = 2'b00; in_carr = 2'b00; in_acion = 2'b00;
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    rst_n = 1'b0; in_clock = '0; in_rst = '0; in_carr = '0; in_acion = '0;
    in_pcm = '0; in_valid = 1'b0; out_ready = 1'b1; stall_prev = 1'b0;
    m_idx = 0; beats = 0; last_out = '0; last_arm = '0;
    foreach (m_hist[k]) m_hist[k] = '0;
    @(negedge clk);

    // Reset, including an offered sample that must be ignored
    cycle();
    in_valid = 1'b1; in_pcm = 65'd77;
    cycle();
    in_valid = 1'b0;
    chk("rst_valid", 65'(out_valid), 65'd0);
    chk("rst_pcm", out_pcm, 65'd0);
    chk("rst_arm", 65'(out_arm), 65'd0);
    chk("rst_in_ready", 65'(in_ready), 65'd1);
    rst_n = 1'b1;

    // Frame 1: samples equal to index, empty history
    beats = 0;
    for (int i = 0; i < 36; i++) send(65'(i));
    cycle();
    chk("f1_beats", 65'(beats), 65'd18);
    chk("f1_last", last_out, 65'd17);
    chk("f1_last_arm", 65'(last_arm), 65'd3);

    // Frame 2: all 100
    beats = 0;
    for (int i = 0; i < 36; i++) send(65'd100);
    cycle();
    chk("f2_beats", 65'(beats), 65'd18);
    chk("f2_last", last_out, 65'd135);

    // Frame 3 seeds history for saturation cases
    for (int i = 0; i < 36; i++) begin
      if (i < 18)       send(65'd0);
      else if (i == 18) send(65'h0_FFFF_FFFF_FFFF_FFF0);
      else if (i == 19) send(65'h1_0000_0000_0000_0005);
      else              send(65'(i));
    end

    // Frame 4: positive and negative saturation, then a stalled output
    send(65'h20);
    cycle();
    chk("sat_pos", last_out, 65'h0_FFFF_FFFF_FFFF_FFFF);
    send(65'h1_FFFF_FFFF_FFFF_FF00);
    cycle();
    chk("sat_neg", last_out, 65'h1_0000_0000_0000_0000);
    send(65'd42);
    in_valid = 1'b1; in_pcm = 65'd43; out_ready = 1'b0;
    repeat (5) cycle();
    chk("stall_in_ready", 65'(in_ready), 65'd0);
    send(65'd43);
    chk("stall_out", last_out, 65'd62);
    for (int i = 4; i < 36; i++) send(i == 18 ? 65'd7 : 65'(i));

    // Frame 5: bypass at idx0, history clear at idx5
    send(65'd3, 2'b00, 2'b01);
    cycle();
    chk("carregar", last_out, 65'd3);
    for (int i = 1; i < 5; i++) send(65'(10 + i));
    send(65'd55, 2'b01);
    cycle();
    chk("hist_clear", last_out, 65'd55);
    send(65'd66);
    cycle();
    chk("after_clear", last_out, 65'd66);
    for (int i = 7; i < 36; i++) send(i < 18 ? 65'(i) : 65'(200 + i));

    // Frame 6: acionar restarts the counter mid-frame
    for (int i = 0; i < 10; i++) send(65'(1000 + i));
    send(65'd5, 2'b00, 2'b00, 2'b01);
    cycle();
    chk("acionar", last_out, 65'd223);

    // Mid-frame reset discards the partial frame and history
    for (int i = 0; i < 25; i++) send(65'(i));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    send(65'd9);
    cycle();
    chk("post_reset_idx0", last_out, 65'd9);

    // Random traffic with backpressure, extreme values and sparse control flags
    repeat (1500) begin
      w0 = $urandom(); w1 = $urandom(); w2 = $urandom();
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      rst_n     = ($urandom_range(199) != 0);
      in_clock  = 2'($urandom());
      in_rst    = {w2[1], ($urandom_range(49) == 0)};
      in_carr   = {w2[2], ($urandom_range(29) == 0)};
      in_acion  = {w2[3], ($urandom_range(39) == 0)};
      case (w2[5:4])
        2'd0:    in_pcm = {{57{w0[7]}}, w0[7:0]};
        2'd1:    in_pcm = {1'b0, 32'hFFFF_FFFF, w0};
        2'd2:    in_pcm = {1'b1, 32'h0000_0000, w0};
        default: in_pcm = {w2[0], w1, w0};
      endcase
      cycle();
    end

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_rst = '0; in_carr = '0; in_acion = '0;
    cycle();
    cycle();
    chk("drained", 65'(q_pcm.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/overlap.md
OVERLAP -- requirements
Module: overlap

Interface
REQ-001 Parameter FRAME_LEN, default 36: input samples per frame; SHALL be even and >= 4.
REQ-002 Parameter HALF, default FRAME_LEN/2: output samples per frame and history depth.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low.
REQ-005 in_overlap_clock  input  2  reserved payload field; SHALL be ignored.
REQ-006 in_overlap_reset  input  2  bit0=1 clears history at this sample; bit1 reserved.
REQ-007 in_overlap_carregar  input  2  bit0=1 on a first-half sample means bypass: output = input, no history add; bit1 reserved.
REQ-008 in_overlap_acionar  input  2  bit0=1 marks frame start and forces sample index to 0; bit1 reserved.
REQ-009 in_overlap_pcmSample  input  65  signed two's-complement IMDCT sample.
REQ-010 in_overlap_valid  input  1  input payload valid.
REQ-011 in_overlap_ready  output  1  DUT accepts input this cycle.
REQ-012 out_overlap_pcmSample  output  65  signed overlapped PCM sample.
REQ-013 out_overlap_armazenarDados  output  2  bit0=1 on every output beat; bit1=1 on last output of frame (index HALF-1).
REQ-014 out_overlap_valid  output  1  output payload valid.
REQ-015 out_overlap_ready  input  1  downstream accepts output.

Function
REQ-016 An input transfer SHALL occur when in_overlap_valid and in_overlap_ready are both 1 on a clk edge; an output transfer SHALL occur when out_overlap_valid and out_overlap_ready are both 1.
REQ-017 An index counter idx SHALL advance 0..FRAME_LEN-1 per input transfer and wrap to 0 after FRAME_LEN-1; acionar bit0=1 SHALL make the current sample idx 0.
REQ-018 History buffer hist[0..HALF-1], 65 bits each, SHALL hold the second half of the previous frame.
REQ-019 First-half sample (idx < HALF): the DUT SHALL register out = sat(in + hist[idx]), or out = in if carregar bit0=1, and assert out_overlap_valid on the next cycle (latency 1).
REQ-020 Second-half sample (idx >= HALF): the DUT SHALL write in into hist[idx-HALF] and produce no output beat.
REQ-021 The sum SHALL be computed at 66 bits and saturated to the signed 65-bit range: positive overflow -> 0x0_FFFF_FFFF_FFFF_FFFF, negative overflow -> 0x1_0000_0000_0000_0000.
REQ-022 If in_overlap_reset bit0=1 on a transfer, all hist entries SHALL become 0 and that sample SHALL use hist=0; a second-half sample in that case SHALL still be stored after the clear.
REQ-023 in_overlap_ready SHALL be (!out_overlap_valid || out_overlap_ready); second-half samples SHALL obey the same rule.
REQ-024 While out_overlap_valid=1 and out_overlap_ready=0, the output pcmSample, armazenarDados and valid SHALL hold stable.
REQ-025 With continuous valid and ready, throughput SHALL be one input per cycle without bubbles.
REQ-026 out_overlap_armazenarDados SHALL be 2'b00 whenever out_overlap_valid=0.

Reset
REQ-027 When reset=0 at a clk edge, the DUT SHALL set idx=0, all hist=0, out_overlap_valid=0, out_overlap_pcmSample=0, and out_overlap_armazenarDados=0.
REQ-028 During reset, in_overlap_ready SHALL read 1 because out_overlap_valid=0.
REQ-029 Input transfers SHALL be ignored in any cycle where reset=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the next transfer after reset is idx 0.

Verification
REQ-031 After reset, first frame of samples i (i=0..35): 18 outputs 0..17 with hist=0; last beat has armazenarDados=2'b11, others 2'b01.
REQ-032 Second frame of all 100: outputs 100+18..100+35, i.e. 118..135.
REQ-033 hist[0]=0x0_FFFF_FFFF_FFFF_FFF0 and input 0x20 at idx0: output saturates to 0x0_FFFF_FFFF_FFFF_FFFF.
REQ-034 Hold out_overlap_ready=0 for 5 cycles with output pending: output stable, in_overlap_ready=0, no sample lost.
REQ-035 carregar bit0=1 at idx0 with hist[0]=7 and input 3: output 3. Separately, in_overlap_reset bit0=1 at idx5 of frame 2: output equals input, and the rest of that frame uses hist=0.
REQ-036 acionar bit0=1 at idx 10: counter restarts, and that sample is output as idx 0 plus hist[0].
